// File: rtl/memstage.sv
// memstage: memory stage of the pipelined MIPS core.
// Issues data-memory loads/stores on a req/ack bus, stalls upstream while a
// transaction is outstanding, drains killed transactions, and registers the
// write-back values (ME-stage bypass and register-file write port).
//
// Handshake: DmReq rises with the address/data/we on the bus and stays high,
// with bus contents stable, until the cycle DmAck is seen high (transaction
// done, DmRdDat valid that cycle) or the wait budget expires.
module memstage #(
   parameter int unsigned WAIT_MAX = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic [31:0] Result_EX,
   input  logic [31:0] WrDat_EX,
   input  logic [4:0]  WriteReg_EX,
   input  logic        RegWrite_EX,
   input  logic        MemToReg_EX,
   input  logic        MemWrite_EX,
   input  logic        InstrVal_EX,
   output logic        DmReq,
   output logic        DmWe,
   output logic [31:0] DmAddr,
   output logic [31:0] DmWrDat,
   input  logic        DmAck,
   input  logic [31:0] DmRdDat,
   output logic        MemStall_ME,
   output logic [31:0] ResultRdDat_ME,
   output logic [4:0]  WriteReg_ME,
   output logic        RegWrite_ME,
   output logic        InstrVal_ME,
   output logic        BusErr_ME,
   output logic [1:0]  DbgState_ME
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

   logic [1:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        buserr_q, buserr_d;

   // copies of the issued op, used by the bus and retire path after issue
   logic [31:0] h_res_q, h_wrdat_q;
   logic [4:0]  h_wreg_q;
   logic        h_we_q, h_regwr_q, h_mtr_q;

   logic [31:0] res_q, res_d;
   logic [4:0]  wreg_q, wreg_d;
   logic        regwr_q, regwr_d;
   logic        ival_q, ival_d;

   logic        memop, is_idle, issue, timeout;

   assign memop   = InstrVal_EX & (MemToReg_EX | MemWrite_EX);
   assign is_idle = (state_q == S_IDLE);
   assign issue   = is_idle & memop & ~flush;
   assign timeout = ~is_idle & ~DmAck & (cnt_q == CNT_LAST);

   // Bus drive: live EX inputs while idle, held copies while a transaction is open.
   // rst_n gates the request so an abandoned transaction drops at once.
   assign DmReq   = rst_n & (is_idle ? (memop & ~flush) : 1'b1);
   assign DmWe    = is_idle ? MemWrite_EX : h_we_q;
   assign DmAddr  = is_idle ? {Result_EX[31:2], 2'b00} : {h_res_q[31:2], 2'b00};
   assign DmWrDat = is_idle ? WrDat_EX : h_wrdat_q;

   assign MemStall_ME = rst_n & ~flush &
                        ((is_idle & memop & ~DmAck) |
                         ((state_q == S_WAIT) & ~DmAck & ~timeout) |
                         ((state_q == S_DRAIN) & memop));

   assign ResultRdDat_ME = res_q;
   assign WriteReg_ME    = wreg_q;
   assign RegWrite_ME    = regwr_q;
   assign InstrVal_ME    = ival_q;
   assign BusErr_ME      = buserr_q;
   assign DbgState_ME    = state_q;

   // Controller next state, wait counter, and the value the ME register loads (bubble by default).
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      buserr_d = buserr_q;
      res_d    = '0;
      wreg_d   = '0;
      regwr_d  = 1'b0;
      ival_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (!memop) begin
               res_d   = Result_EX;
               wreg_d  = WriteReg_EX;
               regwr_d = RegWrite_EX;
               ival_d  = InstrVal_EX;
            end else if (DmAck) begin
               res_d   = MemToReg_EX ? DmRdDat : Result_EX;
               wreg_d  = WriteReg_EX;
               regwr_d = RegWrite_EX;
               ival_d  = 1'b1;
            end else begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            if (DmAck && !flush) begin
               res_d   = h_mtr_q ? DmRdDat : h_res_q;
               wreg_d  = h_wreg_q;
               regwr_d = h_regwr_q;
               ival_d  = 1'b1;
               state_d = S_IDLE;
            end else if (DmAck) begin
               state_d = S_IDLE;
            end else if (timeout) begin
               state_d  = S_IDLE;
               buserr_d = 1'b1;
            end else if (flush) begin
               state_d = S_DRAIN;
               cnt_d   = cnt_q + 8'd1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DRAIN: begin
            if (DmAck) begin
               state_d = S_IDLE;
            end else if (timeout) begin
               state_d  = S_IDLE;
               buserr_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Controller state, counter, sticky error and ME write-back registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         buserr_q <= 1'b0;
         res_q    <= '0;
         wreg_q   <= '0;
         regwr_q  <= 1'b0;
         ival_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         buserr_q <= buserr_d;
         res_q    <= res_d;
         wreg_q   <= wreg_d;
         regwr_q  <= regwr_d;
         ival_q   <= ival_d;
      end
   end

   // Capture the op on every idle-cycle issue so the bus stays stable after flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_res_q   <= '0;
         h_wrdat_q <= '0;
         h_wreg_q  <= '0;
         h_we_q    <= 1'b0;
         h_regwr_q <= 1'b0;
         h_mtr_q   <= 1'b0;
      end else if (issue) begin
         h_res_q   <= Result_EX;
         h_wrdat_q <= WrDat_EX;
         h_wreg_q  <= WriteReg_EX;
         h_we_q    <= MemWrite_EX;
         h_regwr_q <= RegWrite_EX;
         h_mtr_q   <= MemToReg_EX;
      end
   end

endmodule
